traffic_conflict_monitor: RTL and testbench
===========================================

TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter YEL_MIN, default 3: minimum yellow dwell in clk cycles; legal range 1..255.
REQ-002 Parameter DWELL_W, default 8: width of the per-head dwell counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 hwy  input  2  highway signal head from the controller: 0=RED, 1=YELLOW, 2=GREEN, 3=illegal.
REQ-006 cntry  input  2  country-road signal head, same encoding as hwy.
REQ-007 fault  output  1  sticky fault flag, registered.
REQ-008 fault_code  output  3  code of the first latched fault, registered; 0 = none.
REQ-009 flash_req  output  1  request to force all-red flash; equals fault, registered.
REQ-010 armed  output  1  high while in MONITOR state.
REQ-011 cycle_count  output  8  count of completed highway YELLOW->RED transitions.

Function
REQ-012 The FSM SHALL have three states: SYNC, MONITOR, FAULT.
- SYNC: entered from reset. Stays until a sampled pair has at least one head RED and neither head 3. Then goes to MONITOR at that edge.
- MONITOR: checks every sampled pair against REQ-014..REQ-018.
- FAULT: absorbing. Left only by reset.
REQ-013 Each edge, hwy/cntry SHALL be registered into hwy_q/cntry_q. Checks SHALL compare the current inputs against hwy_q/cntry_q and the dwell counters. A violating sample at edge N SHALL appear on fault/fault_code/flash_req after edge N, which is one-cycle latency.
REQ-014 Code 1 (conflict): in MONITOR, neither head is RED.
REQ-015 Code 2 (illegal encoding): in MONITOR, either head equals 3.
REQ-016 Code 3 (illegal transition): in MONITOR, any head changes GREEN->RED, RED->YELLOW, or YELLOW->GREEN. Legal changes are RED->GREEN, GREEN->YELLOW and YELLOW->RED. An unchanged value is always legal.
REQ-017 Code 4 (short yellow): in MONITOR, a head changes YELLOW->RED while its dwell count is below YEL_MIN (only with MON_TIMING_CHECK_EN, see REQ-026).
REQ-018 When several codes fire in the same cycle, the lowest code number SHALL be latched.
REQ-019 A fault SHALL move the FSM to FAULT and set fault=1 and flash_req=1. fault_code SHALL hold the latched code until reset. Later violations SHALL NOT change it.
REQ-020 Dwell counters, per head:
- reset to 1 on any value change, otherwise increment;
- saturate at 2^DWELL_W-1;
- run in all states.
REQ-021 cycle_count SHALL increment by 1 on each legal hwy YELLOW->RED transition in MONITOR. It wraps 255->0 and is frozen in SYNC and FAULT.
REQ-022 armed SHALL be 1 exactly when the state is MONITOR.
REQ-023 In SYNC, inputs SHALL be tracked (hwy_q, cntry_q, dwell counters) but no fault SHALL be raised.

Reset
REQ-024 On reset, all of the following SHALL be set at that edge, overriding any simultaneous violation:
- state=SYNC;
- fault=0, fault_code=0, flash_req=0, armed=0, cycle_count=0;
- hwy_q=0, cntry_q=0;
- dwell counters=1.
REQ-025 Reset asserted mid-FAULT or mid-MONITOR SHALL restart the monitor in SYNC, with the first post-reset sample handled per REQ-012.

Configuration
REQ-026 Macro MON_TIMING_CHECK_EN:
- When defined, code 4 SHALL be checked.
- When undefined, code 4 SHALL never be raised and the dwell counters MAY be removed. All other behaviour is unchanged.

Verification
REQ-027 Reset, then hwy=2, cntry=0 held 5 cycles -> armed=1 after first edge, fault=0, fault_code=0.
REQ-028 Armed, hwy 2->1 (held 3 cycles)->0, cntry=0, repeated twice -> cycle_count=2, fault=0 (with MON_TIMING_CHECK_EN, YEL_MIN=3).
REQ-029 Armed, hwy=2 and cntry changes 0->2 at edge N -> after edge N, fault=1, fault_code=1, flash_req=1. After a further 10 cycles of arbitrary input, fault_code is still 1.
REQ-030 Armed, hwy 2->0 directly -> fault_code=3. Separately, hwy=3 together with cntry=2 -> fault_code=1, because code 1 beats code 2.
REQ-031 YEL_MIN=3, hwy yellow held 2 cycles then RED -> with macro, fault_code=4; without macro, fault=0 and cycle_count increments.
REQ-032 In FAULT, reset=1 for one edge, then hwy=0, cntry=0 -> all outputs 0 and armed=1 after next edge.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Two-head signal monitor: checks conflicts, illegal encodings and transitions, latches the first fault.
// Define MON_TIMING_CHECK_EN to enable the short-yellow check (code 4) and its dwell counters.
module traffic_conflict_monitor #(
  parameter int YEL_MIN = 3,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_req,
  output logic       armed,
  output logic [7:0] cycle_count
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;
  localparam logic [1:0] ILL = 2'd3;

  state_t     state;
  logic [1:0] hwy_q, cntry_q;
  logic       c_conflict, c_illegal, c_step, c_short;
  logic [2:0] code;
  logic       sync_ok;

  function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == GRN && cur == RED) || (prev == RED && cur == YEL) ||
           (prev == YEL && cur == GRN);
  endfunction

`ifdef MON_TIMING_CHECK_EN
  localparam logic [DWELL_W-1:0] YEL_MIN_W = DWELL_W'(YEL_MIN);
  logic [DWELL_W-1:0] hwy_dwell, cntry_dwell;

  // Dwell = number of consecutive edges the registered value has been held.
  always_ff @(posedge clk) begin
    if (reset) begin
      hwy_dwell   <= DWELL_W'(1);
      cntry_dwell <= DWELL_W'(1);
    end else begin
      if (hwy != hwy_q)          hwy_dwell <= DWELL_W'(1);
      else if (hwy_dwell != '1)  hwy_dwell <= hwy_dwell + DWELL_W'(1);
      if (cntry != cntry_q)         cntry_dwell <= DWELL_W'(1);
      else if (cntry_dwell != '1)   cntry_dwell <= cntry_dwell + DWELL_W'(1);
    end
  end

  assign c_short = (hwy_q == YEL && hwy == RED && hwy_dwell < YEL_MIN_W) ||
                   (cntry_q == YEL && cntry == RED && cntry_dwell < YEL_MIN_W);
`else
  assign c_short = 1'b0;
`endif

  assign c_conflict = (hwy != RED) && (cntry != RED);
  assign c_illegal  = (hwy == ILL) || (cntry == ILL);
  assign c_step     = bad_step(hwy_q, hwy) || bad_step(cntry_q, cntry);
  assign sync_ok    = (hwy == RED || cntry == RED) && hwy != ILL && cntry != ILL;

  // Lowest code number wins when several fire together.
  always_comb begin
    code = 3'd0;
    if (c_short)    code = 3'd4;
    if (c_step)     code = 3'd3;
    if (c_illegal)  code = 3'd2;
    if (c_conflict) code = 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      flash_req   <= 1'b0;
      armed       <= 1'b0;
      cycle_count <= 8'd0;
      hwy_q       <= RED;
      cntry_q     <= RED;
    end else begin
      hwy_q   <= hwy;
      cntry_q <= cntry;
      case (state)
        SYNC: begin
          if (sync_ok) begin
            state <= MONITOR;
            armed <= 1'b1;
          end
        end
        MONITOR: begin
          if (code != 3'd0) begin
            state      <= FAULT;
            armed      <= 1'b0;
            fault      <= 1'b1;
            flash_req  <= 1'b1;
            fault_code <= code;
          end else if (hwy_q == YEL && hwy == RED) begin
            cycle_count <= cycle_count + 8'd1;
          end
        end
        FAULT: ;
        default: begin
          state <= SYNC;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Randomized bench for traffic_conflict_monitor against a rule-level reference model.
module tb_traffic_conflict_monitor;

  localparam int YEL_MIN = 3;
  localparam int DWELL_W = 8;
  localparam int DWELL_MAX = (1 << DWELL_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] hwy = 2'd0;
  logic [1:0] cntry = 2'd0;
  logic       fault, flash_req, armed;
  logic [2:0] fault_code;
  logic [7:0] cycle_count;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state: phase 0=sync, 1=monitoring, 2=faulted
  int m_phase, m_code, m_cnt, m_hq, m_cq, m_dh, m_dc;

  traffic_conflict_monitor #(.YEL_MIN(YEL_MIN), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .hwy(hwy), .cntry(cntry),
    .fault(fault), .fault_code(fault_code), .flash_req(flash_req),
    .armed(armed), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // A head may only move along the cycle RED -> GREEN -> YELLOW -> RED.
  function automatic bit step_ok(input int prev, input int cur);
    return (cur == prev) || (cur == (prev + 2) % 3);
  endfunction

  function automatic void model_edge(input int h, input int c, input bit r);
    int code;
    if (r) begin
      m_phase = 0; m_code = 0; m_cnt = 0;
      m_hq = 0; m_cq = 0; m_dh = 1; m_dc = 1;
      return;
    end
    code = 0;
    if (m_phase == 1) begin
      if (h != 0 && c != 0)                          code = 1;
      else if (h == 3 || c == 3)                     code = 2;
      else if (!step_ok(m_hq, h) || !step_ok(m_cq, c)) code = 3;
`ifdef MON_TIMING_CHECK_EN
      else if ((m_hq == 1 && h == 0 && m_dh < YEL_MIN) ||
               (m_cq == 1 && c == 0 && m_dc < YEL_MIN)) code = 4;
`endif
      if (code != 0) begin
        m_phase = 2;
        m_code = code;
      end else if (m_hq == 1 && h == 0) begin
        m_cnt = (m_cnt + 1) % 256;
      end
    end else if (m_phase == 0) begin
      if ((h == 0 || c == 0) && h != 3 && c != 3) m_phase = 1;
    end
    m_dh = (h != m_hq) ? 1 : ((m_dh + 1 > DWELL_MAX) ? DWELL_MAX : m_dh + 1);
    m_dc = (c != m_cq) ? 1 : ((m_dc + 1 > DWELL_MAX) ? DWELL_MAX : m_dc + 1);
    m_hq = h;
    m_cq = c;
  endfunction

  task automatic step(input int h, input int c, input bit r = 1'b0);
    @(negedge clk);
    hwy = 2'(h);
    cntry = 2'(c);
    reset = r;
    @(posedge clk);
    model_edge(h, c, r);
    #1;
    check("fault", 32'(fault), 32'(m_phase == 2));
    check("fault_code", 32'(fault_code), 32'(m_code));
    check("flash_req", 32'(flash_req), 32'(m_phase == 2));
    check("armed", 32'(armed), 32'(m_phase == 1));
    check("cycle_count", 32'(cycle_count), 32'(m_cnt));
  endtask

  initial begin
    int h, c, pick;
    // Reset, then hwy green / cntry red arms after the first edge.
    step(2, 0, 1'b1);
    check("reset_fault_code", 32'(fault_code), 0);
    check("reset_armed", 32'(armed), 0);
    step(2, 0);
    check("arm_first_edge", 32'(armed), 1);
    repeat (4) step(2, 0);
    check("arm_no_fault", 32'(fault), 0);

    // Two full yellow cycles of 3 cycles each.
    repeat (2) begin
      repeat (3) step(1, 0);
      step(0, 0);
      step(2, 0);
    end
    check("two_cycles_count", 32'(cycle_count), 2);
    check("two_cycles_fault", 32'(fault), 0);

    // Conflict, then noise must not change the latched code.
    step(2, 2);
    check("conflict_code", 32'(fault_code), 1);
    check("conflict_flash", 32'(flash_req), 1);
    repeat (10) step($urandom_range(0, 3), $urandom_range(0, 3));
    check("conflict_sticky", 32'(fault_code), 1);

    // Green straight to red.
    step(2, 0, 1'b1);
    step(2, 0);
    step(0, 0);
    check("g2r_code", 32'(fault_code), 3);

    // Illegal encoding alongside a conflict: conflict wins.
    step(0, 0, 1'b1);
    step(0, 0);
    step(2, 0);
    step(3, 2);
    check("code1_beats_2", 32'(fault_code), 1);

    // Short yellow.
    step(0, 0, 1'b1);
    step(0, 0);
    step(2, 0);
    repeat (2) step(1, 0);
    step(0, 0);
`ifdef MON_TIMING_CHECK_EN
    check("short_yellow_code", 32'(fault_code), 4);
`else
    check("short_yellow_nofault", 32'(fault), 0);
    check("short_yellow_count", 32'(cycle_count), 1);
`endif

    // Long yellow past dwell saturation must stay legal.
    step(0, 0, 1'b1);
    step(0, 0);
    step(2, 0);
    repeat (257) step(1, 0);
    step(0, 0);
    check("saturated_dwell_fault", 32'(fault), 0);
    check("saturated_dwell_count", 32'(cycle_count), 1);

    // Reset wins over a simultaneous violation, then re-arm.
    step(2, 2);
    step(3, 3, 1'b1);
    check("reset_override_fault", 32'(fault), 0);
    check("reset_override_armed", 32'(armed), 0);
    step(0, 0);
    check("rearm", 32'(armed), 1);
    check("rearm_code", 32'(fault_code), 0);

    // Random mostly-legal controller with occasional corruption and resets.
    h = 0; c = 0;
    step(0, 0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 2) begin
        h = 0; c = 0;
        step(h, c, 1'b1);
      end else if (pick < 4) begin
        h = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        step(h, c);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          if (h == 3 || c == 3) begin
            h = 0; c = 0;
          end else if (h != 0) h = (h + 2) % 3;
          else if (c != 0) c = (c + 2) % 3;
          else if ($urandom_range(0, 1) == 0) h = 2;
          else c = 2;
        end
        step(h, c);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
